// File: rtl/chaos_seq_pkg.sv
// chaos_seq_pkg
// Shared constants for the chaos reset sequencer: register addresses,
// CTRL bit positions, STATUS bit offsets (relative to CNT_W) and the
// sequencer state encoding.
package chaos_seq_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_HOLD   = 2'd1;
    localparam logic [1:0] ADDR_SETTLE = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_AUTO_BIT  = 1;
    localparam int CTRL_ABORT_BIT = 2;
    localparam int CTRL_BUSY_BIT  = 0;

    // STATUS layout: [CNT_W-1:0] count, then busy, then DONE_STICKY.
    localparam int STATUS_BUSY_OFS   = 0;
    localparam int STATUS_STICKY_OFS = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_SETTLE = 2'd2
    } seq_state_e;

endpackage

// File: rtl/chaos_seq_timer.sv
// chaos_seq_timer
// Loadable down-counter shared by the HOLD and SETTLE phases.
//   clk, reset    : clock, synchronous active-high reset
//   load          : load load_value this cycle (takes priority over counting)
//   load_value    : value to load, expected >= 1
//   value         : current count
//   expire        : terminal count, high in the last cycle of the loaded period
module chaos_seq_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    output logic [CNT_W-1:0] value,
    output logic             expire
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_value;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A load of N gives N cycles; the N-th one sees the count at 1.
    assign value  = cnt_q;
    assign expire = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/chaos_reset_sequencer.sv
// chaos_reset_sequencer
// Avalon-MM slave that produces timed reset pulses for the chaos datapath:
// reset held for HOLD cycles, released for SETTLE cycles, then a one-cycle
// seq_done, optionally repeating (AUTO).
//   clk, reset                         : clock, synchronous active-high reset
//   address, chipselect, write_n,
//   writedata, readdata                : zero-wait-state register interface
//   chaos_reset                        : reset to the chaos datapath (registered)
//   seq_done                           : one-cycle completion pulse (registered)
//   busy                               : high in HOLD or SETTLE
//
// state     | meaning
// ----------+---------------------------------------------
// ST_IDLE   | waiting for START or AUTO restart
// ST_HOLD   | chaos_reset asserted, timer running HOLD
// ST_SETTLE | chaos_reset released, timer running SETTLE
module chaos_reset_sequencer
    import chaos_seq_pkg::*;
#(
    parameter int CNT_W          = 16,
    parameter int HOLD_DEFAULT   = 16,
    parameter int SETTLE_DEFAULT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        chaos_reset,
    output logic        seq_done,
    output logic        busy
);

    localparam int STATUS_BUSY_BIT   = CNT_W + STATUS_BUSY_OFS;
    localparam int STATUS_STICKY_BIT = CNT_W + STATUS_STICKY_OFS;

    seq_state_e       state_q, state_d;
    logic             auto_q, auto_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0] settle_q, settle_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             sticky_q, sticky_d;
    logic             chaos_reset_q, chaos_reset_d;
    logic             seq_done_q, seq_done_d;

    logic             wr_en, wr_ctrl, wr_hold, wr_settle, wr_status;
    logic             start_req, abort_req, w1c_sticky;
    logic [CNT_W-1:0] hold_eff, settle_eff;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_load_value;
    logic [CNT_W-1:0] tmr_value;
    logic             tmr_expire;
    logic             done_evt;

    assign wr_en      = chipselect && !write_n;
    assign wr_ctrl    = wr_en && (address == ADDR_CTRL);
    assign wr_hold    = wr_en && (address == ADDR_HOLD);
    assign wr_settle  = wr_en && (address == ADDR_SETTLE);
    assign wr_status  = wr_en && (address == ADDR_STATUS);
    assign start_req  = wr_ctrl && writedata[CTRL_START_BIT];
    assign abort_req  = wr_ctrl && writedata[CTRL_ABORT_BIT];
    assign w1c_sticky = wr_status && writedata[STATUS_STICKY_BIT];

    // A programmed 0 behaves as 1 so every phase lasts at least one cycle.
    assign hold_eff   = (hold_q   == '0) ? CNT_W'(1) : hold_q;
    assign settle_eff = (settle_q == '0) ? CNT_W'(1) : settle_q;

    chaos_seq_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (tmr_load),
        .load_value (tmr_load_value),
        .value      (tmr_value),
        .expire     (tmr_expire)
    );

    always_comb begin
        state_d        = state_q;
        tmr_load       = 1'b0;
        tmr_load_value = hold_eff;
        done_evt       = 1'b0;
        if (abort_req) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_req || auto_q) begin
                        state_d        = ST_HOLD;
                        tmr_load       = 1'b1;
                        tmr_load_value = hold_eff;
                    end
                end
                ST_HOLD: begin
                    if (tmr_expire) begin
                        state_d        = ST_SETTLE;
                        tmr_load       = 1'b1;
                        tmr_load_value = settle_eff;
                    end
                end
                ST_SETTLE: begin
                    if (tmr_expire) begin
                        state_d  = ST_IDLE;
                        done_evt = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        auto_d = auto_q;
        if (abort_req) begin
            auto_d = 1'b0;
        end else if (wr_ctrl) begin
            auto_d = writedata[CTRL_AUTO_BIT];
        end

        hold_d   = wr_hold   ? writedata[CNT_W-1:0] : hold_q;
        settle_d = wr_settle ? writedata[CNT_W-1:0] : settle_q;
        count_d  = done_evt  ? count_q + CNT_W'(1)  : count_q;

        // A clear landing on the completion edge or the seq_done cycle loses.
        sticky_d = done_evt || seq_done_q || (sticky_q && !w1c_sticky);

        chaos_reset_d = (state_d == ST_HOLD);
        seq_done_d    = done_evt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            auto_q        <= 1'b0;
            hold_q        <= CNT_W'(HOLD_DEFAULT);
            settle_q      <= CNT_W'(SETTLE_DEFAULT);
            count_q       <= '0;
            sticky_q      <= 1'b0;
            chaos_reset_q <= 1'b0;
            seq_done_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            auto_q        <= auto_d;
            hold_q        <= hold_d;
            settle_q      <= settle_d;
            count_q       <= count_d;
            sticky_q      <= sticky_d;
            chaos_reset_q <= chaos_reset_d;
            seq_done_q    <= seq_done_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign chaos_reset = chaos_reset_q;
    assign seq_done    = seq_done_q;

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_CTRL: begin
                readdata[CTRL_BUSY_BIT] = busy;
                readdata[CTRL_AUTO_BIT] = auto_q;
            end
            ADDR_HOLD:   readdata[CNT_W-1:0] = hold_q;
            ADDR_SETTLE: readdata[CNT_W-1:0] = settle_q;
            ADDR_STATUS: begin
                readdata[CNT_W-1:0]        = count_q;
                readdata[STATUS_BUSY_BIT]   = busy;
                readdata[STATUS_STICKY_BIT] = sticky_q;
            end
            default: readdata = '0;
        endcase
    end

    logic unused_bits;
    assign unused_bits = ^{writedata, tmr_value};

endmodule
